rvfi_trace_checker: RTL

Consumer-side checker for the RVFI retirement stream produced by the core's RVFI monitor. It samples every `rvfi_valid` retirement and keeps a shadow architectural register file, an expected program counter and an expected order number. It flags the first retirement that is inconsistent with the stream so far, latching an error code and the offending order/PC. It sits beside the core in simulation and formal benches, and its outputs feed the contract-generation harness as a trace-sanity gate.

---
 rtl/rvfi_trace_checker.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rvfi_trace_checker.sv
// RVFI retirement-stream sanity checker.
// Shadows the register file, PC and order; latches the first bad retirement.
module rvfi_trace_checker #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          CHECK_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic        rvfi_trap,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [63:0] err_order,
    output logic [31:0] err_pc,
    output logic [31:0] retired_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_FAIL = 1'b1
    } state_t;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_ORDER = 3'd1;
    localparam logic [2:0] C_PC    = 3'd2;
    localparam logic [2:0] C_RS1   = 3'd3;
    localparam logic [2:0] C_RS2   = 3'd4;
    localparam logic [2:0] C_RD0   = 3'd5;
    localparam logic [2:0] C_MEM   = 3'd6;
    localparam logic [2:0] C_TRAP  = 3'd7;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_exp_order;
    logic [31:0] r_exp_pc;
    logic [31:0] r_shadow [0:31];
    logic [31:0] r_known;

    logic        r_err;
    logic [2:0]  r_err_code;
    logic [63:0] r_err_order;
    logic [31:0] r_err_pc;
    logic [31:0] r_retired;

    logic        w_ord_bad;
    logic        w_pc_bad;
    logic        w_rs1_bad;
    logic        w_rs2_bad;
    logic        w_rd0_bad;
    logic        w_mem_bad;
    logic        w_trap_bad;
    logic        w_same_src;
    logic        w_rs2_ref_known;
    logic [31:0] w_rs2_ref;
    logic [2:0]  w_code;
    logic        w_check;
    logic        w_accept;
    logic        w_reject;

    assign w_check = (r_state == S_RUN) && rvfi_valid;

    // Evaluate every consistency check against the current shadow state
    always_comb begin
        w_ord_bad  = rvfi_order != r_exp_order;
        w_pc_bad   = rvfi_pc_rdata != r_exp_pc;
        w_rd0_bad  = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
        w_mem_bad  = (rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0);
        w_trap_bad = rvfi_trap && CHECK_TRAP;

        if (rvfi_rs1_addr == 5'd0) begin
            w_rs1_bad = rvfi_rs1_rdata != 32'd0;
        end else begin
            w_rs1_bad = r_known[rvfi_rs1_addr] &&
                        (rvfi_rs1_rdata != r_shadow[rvfi_rs1_addr]);
        end

        // An rs1 learn to the same index is visible to the rs2 compare
        w_same_src = (rvfi_rs2_addr == rvfi_rs1_addr) &&
                     (rvfi_rs2_addr != 5'd0);
        w_rs2_ref_known = r_known[rvfi_rs2_addr] | w_same_src;
        if (w_same_src && !r_known[rvfi_rs2_addr]) begin
            w_rs2_ref = rvfi_rs1_rdata;
        end else begin
            w_rs2_ref = r_shadow[rvfi_rs2_addr];
        end

        if (rvfi_rs2_addr == 5'd0) begin
            w_rs2_bad = rvfi_rs2_rdata != 32'd0;
        end else begin
            w_rs2_bad = w_rs2_ref_known && (rvfi_rs2_rdata != w_rs2_ref);
        end
    end

    // Lowest-numbered failing check wins
    always_comb begin
        w_code = C_NONE;
        if (w_ord_bad) begin
            w_code = C_ORDER;
        end else if (w_pc_bad) begin
            w_code = C_PC;
        end else if (w_rs1_bad) begin
            w_code = C_RS1;
        end else if (w_rs2_bad) begin
            w_code = C_RS2;
        end else if (w_rd0_bad) begin
            w_code = C_RD0;
        end else if (w_mem_bad) begin
            w_code = C_MEM;
        end else if (w_trap_bad) begin
            w_code = C_TRAP;
        end
    end

    assign w_reject = w_check && (w_code != C_NONE);
    assign w_accept = w_check && (w_code == C_NONE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: FAIL is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (w_reject) w_state_nxt = S_FAIL;
            S_FAIL:  w_state_nxt = S_FAIL;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Expected order/PC and saturating retirement count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exp_order <= 64'd1;
            r_exp_pc    <= RESET_PC;
            r_retired   <= 32'd0;
        end else if (w_accept) begin
            r_exp_order <= r_exp_order + 64'd1;
            r_exp_pc    <= rvfi_pc_wdata;
            if (r_retired != 32'hFFFF_FFFF) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Known bits: learn from sources, set on rd write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_known <= 32'd0;
        end else if (w_accept) begin
            for (int i = 1; i < 32; i++) begin
                if ((rvfi_rs1_addr == 5'(i)) ||
                    (rvfi_rs2_addr == 5'(i)) ||
                    (rvfi_rd_addr == 5'(i))) begin
                    r_known[i] <= 1'b1;
                end
            end
        end
    end

    // Shadow values: rs learns first, rd write overrides
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            for (int i = 1; i < 32; i++) begin
                if ((rvfi_rd_addr == 5'(i))) begin
                    r_shadow[i] <= rvfi_rd_wdata;
                end else if ((rvfi_rs1_addr == 5'(i)) && !r_known[i]) begin
                    r_shadow[i] <= rvfi_rs1_rdata;
                end else if ((rvfi_rs2_addr == 5'(i)) && !r_known[i]) begin
                    r_shadow[i] <= rvfi_rs2_rdata;
                end
            end
        end
    end

    // Capture the first failing retirement
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_code  <= C_NONE;
            r_err_order <= 64'd0;
            r_err_pc    <= 32'd0;
        end else if (w_reject) begin
            r_err       <= 1'b1;
            r_err_code  <= w_code;
            r_err_order <= rvfi_order;
            r_err_pc    <= rvfi_pc_rdata;
        end
    end

    assign err           = r_err;
    assign err_code      = r_err_code;
    assign err_order     = r_err_order;
    assign err_pc        = r_err_pc;
    assign retired_count = r_retired;

endmodule
